// File: rtl/ofmap_pkg.sv
// Shared definitions for the ofmap unchainer: default sizes, PISO state
// encoding and the counter-width helper.
package ofmap_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_CHAIN_LEN  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2
    } piso_state_t;

    // A single-word chain still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int CNT_W = cnt_width(DEFAULT_CHAIN_LEN);

endpackage

// File: rtl/piso_word_counter.sv
// Modulo-CHAIN_LEN word counter; terminal count marks the last word of an entry.
module piso_word_counter
    import ofmap_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int W = cnt_width(CHAIN_LEN);
    localparam logic [W-1:0] LAST = W'(CHAIN_LEN - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ofmap_unchain_piso.sv
// Captures one chained double-buffer entry and streams its words, LSB word
// first, over a valid/ready interface to the ofmap sink.
module ofmap_unchain_piso
    import ofmap_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CHAIN_LEN  = DEFAULT_CHAIN_LEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            load,
    input  logic                            start,
    input  logic [DATA_WIDTH*CHAIN_LEN-1:0] chained_data,
    output logic                            ready_to_unchain,
    output logic                            unchaining_last_one,
    output logic [DATA_WIDTH-1:0]           ofmap_dat,
    output logic                            ofmap_valid,
    input  logic                            ofmap_ready,
    output logic [1:0]                      dbg_state_o
);

    // Stream handshake: a word moves on every edge where ofmap_valid and
    // ofmap_ready are both high; ofmap_dat is stable while valid waits for ready.

    localparam int SW = DATA_WIDTH * CHAIN_LEN;

    piso_state_t   state_q, state_d;
    logic [SW-1:0] sreg_q, sreg_d;
    logic          xfer;
    logic          cnt_clr;
    logic          cnt_tc;
    logic          rdy_raw;
    logic          valid_raw;

    piso_word_counter #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .inc_i (xfer),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        rdy_raw   = 1'b0;
        valid_raw = 1'b0;
        xfer      = 1'b0;
        cnt_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    sreg_d  = chained_data;
                    cnt_clr = 1'b1;
                    state_d = LOADED;
                end
            end
            LOADED: begin
                rdy_raw = 1'b1;
                if (load) begin
                    sreg_d  = chained_data;
                    cnt_clr = 1'b1;
                end
                if (start && en) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                valid_raw = en;
                xfer      = en && ofmap_ready;
                if (xfer) begin
                    sreg_d = sreg_q >> DATA_WIDTH;
                    if (cnt_tc) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
        end
    end

    // Outputs are forced low while reset is held, even before the first edge.
    assign ready_to_unchain    = rdy_raw && !rst;
    assign ofmap_valid         = valid_raw && !rst;
    assign unchaining_last_one = xfer && cnt_tc && !rst;
    assign ofmap_dat           = rst ? '0 : sreg_q[DATA_WIDTH-1:0];
    assign dbg_state_o         = state_q;

endmodule

// File: tb/tb_ofmap_unchain_piso.sv
// Bench for ofmap_unchain_piso: directed scenarios plus random traffic,
// checked cycle by cycle against a queue-based model of the entry stream.
module tb_ofmap_unchain_piso;
    import ofmap_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;
    localparam int CL = DEFAULT_CHAIN_LEN;

    logic              clk = 1'b0;
    logic              rst, en, load, start, ofmap_ready;
    logic [DW*CL-1:0]  chained_data;
    logic              ready_to_unchain, unchaining_last_one, ofmap_valid;
    logic [DW-1:0]     ofmap_dat;
    logic [1:0]        dbg_state;

    ofmap_unchain_piso #(.DATA_WIDTH(DW), .CHAIN_LEN(CL)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .load                (load),
        .start               (start),
        .chained_data        (chained_data),
        .ready_to_unchain    (ready_to_unchain),
        .unchaining_last_one (unchaining_last_one),
        .ofmap_dat           (ofmap_dat),
        .ofmap_valid         (ofmap_valid),
        .ofmap_ready         (ofmap_ready),
        .dbg_state_o         (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: a captured entry waiting for start, and the queue of
    // words still owed to the sink once serialisation has begun.
    bit               m_loaded;
    bit               m_shift;
    logic [DW*CL-1:0] m_entry;
    logic [DW-1:0]    exp_q[$];
    logic [DW-1:0]    got_q[$];
    int               total = 0;
    int               bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic l, input logic s,
                        input logic [DW*CL-1:0] d, input logic rdy);
        logic ev;
        @(negedge clk);
        rst = r; en = e; load = l; start = s; chained_data = d; ofmap_ready = rdy;
        #1;
        ev = !r && m_shift && e;
        chk("ready_to_unchain", ready_to_unchain, !r && m_loaded);
        chk("ofmap_valid", ofmap_valid, ev);
        chk("unchaining_last_one", unchaining_last_one, ev && rdy && (exp_q.size() == 1));
        if (ev)     chk("ofmap_dat", ofmap_dat, exp_q[0]);
        else if (r) chk("ofmap_dat_rst", ofmap_dat, 0);
        if (ofmap_valid && ofmap_ready) got_q.push_back(ofmap_dat);
        if (r) begin
            m_loaded = 0; m_shift = 0; exp_q.delete();
        end else if (m_shift) begin
            if (e && rdy) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_shift = 0;
            end
        end else if (m_loaded) begin
            if (l) m_entry = d;
            if (s && e) begin
                m_loaded = 0;
                m_shift  = 1;
                for (int k = 0; k < CL; k++) exp_q.push_back(m_entry[k*DW +: DW]);
            end
        end else if (l) begin
            m_entry  = d;
            m_loaded = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
    endtask

    task automatic chk_words(input string tag, input logic [DW*CL-1:0] entry);
        chk({tag, "_count"}, got_q.size(), CL);
        for (int k = 0; k < CL; k++)
            if (k < got_q.size()) chk({tag, "_word"}, got_q[k], entry[k*DW +: DW]);
    endtask

    logic [DW*CL-1:0] d_a, d_b, d_c;

    initial begin
        rst = 1; en = 0; load = 1; start = 0; ofmap_ready = 0;
        chained_data = 64'h1111_2222_3333_4444;
        m_loaded = 0; m_shift = 0; m_entry = '0;
        d_a = 64'h0004_0003_0002_0001;
        d_b = 64'h0DEF_0ABC_0789_0456;
        d_c = 64'hAAAA_AAAA_AAAA_AAAA;

        // Reset held two cycles with load high: nothing captured.
        step(1, 0, 1, 0, 64'h1111_2222_3333_4444, 0);
        step(1, 0, 1, 0, 64'h1111_2222_3333_4444, 0);
        step(0, 0, 0, 0, '0, 0);
        chk("state_after_reset", dbg_state, IDLE);
        chk("dat_after_reset", ofmap_dat, 0);

        // Basic unchain.
        got_q.delete();
        step(0, 0, 1, 0, d_a, 0);
        step(0, 1, 0, 1, '0, 1);
        for (int i = 0; i < CL; i++) step(0, 1, 0, 0, '0, 1);
        step(0, 1, 0, 0, '0, 1);
        chk_words("basic", d_a);

        // Backpressure on word 2 for three cycles.
        got_q.delete();
        step(0, 0, 1, 0, d_b, 0);
        step(0, 1, 0, 1, '0, 1);
        step(0, 1, 0, 0, '0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, '0, 1);
        chk_words("backpressure", d_b);

        // Enable dropped for two cycles after word 1.
        got_q.delete();
        step(0, 0, 1, 0, d_a, 0);
        step(0, 1, 0, 1, '0, 1);
        step(0, 1, 0, 0, '0, 1);
        step(0, 0, 0, 0, '0, 1);
        step(0, 0, 0, 0, '0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, '0, 1);
        chk_words("en_freeze", d_a);

        // Start while idle does nothing.
        step(0, 1, 0, 1, d_b, 1);
        step(0, 1, 0, 1, d_b, 1);
        chk("start_in_idle_state", dbg_state, IDLE);

        // Load during shifting is ignored.
        got_q.delete();
        step(0, 0, 1, 0, d_b, 0);
        step(0, 1, 0, 1, '0, 1);
        step(0, 1, 0, 0, '0, 1);
        step(0, 1, 1, 0, d_c, 1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, d_c, 1);
        chk_words("load_in_shift", d_b);

        // Second load in LOADED wins.
        got_q.delete();
        step(0, 0, 1, 0, d_a, 0);
        step(0, 0, 1, 0, d_b, 0);
        step(0, 1, 0, 1, '0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, '0, 1);
        chk_words("double_load", d_b);

        // Reset after word 2, then a fresh entry from word 0.
        step(0, 0, 1, 0, d_a, 0);
        step(0, 1, 0, 1, '0, 1);
        step(0, 1, 0, 0, '0, 1);
        step(0, 1, 0, 0, '0, 1);
        step(1, 1, 0, 0, '0, 1);
        step(0, 1, 0, 0, '0, 1);
        chk("state_after_mid_reset", dbg_state, IDLE);
        got_q.delete();
        step(0, 0, 1, 0, d_c ^ d_b, 0);
        step(0, 1, 0, 1, '0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, '0, 1);
        chk_words("after_mid_reset", d_c ^ d_b);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 80),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 40),
                 {$urandom, $urandom},
                 ($urandom_range(0, 99) < 70));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofmap_unchain_piso.md
# ofmap_unchain_piso

Parallel-in/serial-out unchainer between the accumulation double buffer read port and the testbench ofmap sink. Each double-buffer entry holds CHAIN_LEN packed ofmap words. On command from the ofmap read controller, the block captures one entry and emits its words one per accepted transfer over a valid/ready stream. It reports readiness to start (`ready_to_unchain`) and the final transfer of each entry (`unchaining_last_one`) back to the controller.

## Interface
- DATA_WIDTH, 16, width of one ofmap word
- CHAIN_LEN, 4, words per chained entry (≥1)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- en  in  1  shift enable (controller `en_PISO`); gates start and transfers
- load  in  1  capture `chained_data` (not gated by `en`)
- start  in  1  begin serialisation of captured entry
- chained_data  in  DATA_WIDTH*CHAIN_LEN  entry from double buffer; word k = bits [k*DATA_WIDTH +: DATA_WIDTH]
- ready_to_unchain  out  1  entry captured, waiting for start
- unchaining_last_one  out  1  last word of entry transfers this cycle
- ofmap_dat  out  DATA_WIDTH  current output word
- ofmap_valid  out  1  `ofmap_dat` valid
- ofmap_ready  in  1  sink accepts word

## Operation
- States: IDLE, LOADED, SHIFT. Registers: shift register `sreg` (DATA_WIDTH*CHAIN_LEN), word counter `cnt` (clog2(CHAIN_LEN) bits, min 1).
- IDLE: `load`=1 → capture `sreg`, `cnt`=0, go to LOADED.
- LOADED: `ready_to_unchain`=1. `start`&&`en` → SHIFT. `load` recaptures, overwriting the entry, and the state stays LOADED.
- SHIFT: `ofmap_valid`=`en`; `ofmap_dat`=`sreg`[DATA_WIDTH-1:0]. Transfer = `en`&&`ofmap_valid`&&`ofmap_ready`. On transfer, `sreg` shifts right by DATA_WIDTH (zero fill) and `cnt`++.
- `unchaining_last_one` = transfer && `cnt`==CHAIN_LEN-1 (combinational). On that edge → IDLE and `cnt`=0.
- CHAIN_LEN=1: the first transfer is also the last.
- `load` in SHIFT is ignored. `start` in IDLE or SHIFT is ignored.
- `en`=0 in SHIFT: `ofmap_valid`=0 and all state is frozen. Serialisation resumes at the same word when `en` returns.
- Word order: word 0 (LSBs) is output first.

## Timing
- Reset values: state=IDLE, `sreg`=0, `cnt`=0.
- Output values during and after reset: `ready_to_unchain`=0, `unchaining_last_one`=0, `ofmap_valid`=0, `ofmap_dat`=0.
- `rst` mid-operation: the entry is discarded and the block is back in IDLE on the next cycle.
- `chained_data` is sampled on the edge where `load`=1. The buffer has 1-cycle read latency, so `ren` is issued one cycle before `load`.
- `ready_to_unchain` rises the cycle after `load`.
- Start: a cycle with `start`&&`en`&&LOADED puts the block in SHIFT on the next cycle. Word 0 is presented in that cycle.
- Throughput: one word per cycle while `ofmap_ready`=1. Full entry = CHAIN_LEN cycles minimum.
- Backpressure: while `ofmap_valid`=1 and `ofmap_ready`=0, `ofmap_dat` holds stable.
- `unchaining_last_one` is high for exactly one cycle per entry, coincident with the final transfer. The controller leaves its PISO state on that edge.
- Minimum turnaround per entry (load → start → CHAIN_LEN words), with the controller's read/load/start sequence: CHAIN_LEN+3 cycles.

## Structure
- Shared package `ofmap_pkg`:
  - DATA_WIDTH and CHAIN_LEN defaults
  - state enum `piso_state_t` {IDLE, LOADED, SHIFT}
  - localparam CNT_W = max(1, $clog2(CHAIN_LEN))
- Optional sub-module `piso_word_counter`: modulo-CHAIN_LEN up-counter with enable, clear and terminal-count output. Its terminal count drives `unchaining_last_one`.
- Everything else stays in the single module.

## Test plan
- Reset: assert `rst` for 2 cycles with `load`=1 → all outputs 0, no capture; after release, state is IDLE.
- Basic unchain: `chained_data`=0x0004_0003_0002_0001, `load`, then `start`+`en`, `ofmap_ready`=1 → `ofmap_dat` 1,2,3,4 on consecutive cycles. `unchaining_last_one` high only with word 4; `ofmap_valid` low the cycle after.
- Backpressure: as above, `ofmap_ready` low for 3 cycles during word 2 → word 2 held stable with `ofmap_valid`=1, no repeat or skip. `unchaining_last_one` is delayed by 3 cycles.
- En freeze: drop `en` for 2 cycles after word 1 → `ofmap_valid`=0 and no advance; the stream resumes with word 2.
- Ignored commands:
  - `start` in IDLE → no output.
  - `load` during SHIFT with new data 0xAAAA… → the remaining original words still emerge unchanged.
  - `load` twice in LOADED → the second value is serialised.
- Reset mid-SHIFT after word 2 → `ofmap_valid`=0 next cycle and no `unchaining_last_one`. A new `load`/`start` serialises the new entry from word 0.
